updn_bounce_counter: RTL and testbench
======================================

# updn_bounce_counter

Parametrised up/down counter with programmable bounds and three counting modes: wrap-up, wrap-down and bounce (ping-pong). It is the next generation of the team's fixed 4-bit 0..15 ping-pong counter. With the default parameters, `lo=0`, `hi=15`, BOUNCE mode and `en` tied high, it reproduces that counter's sequence exactly. It adds enable, parallel load, runtime bounds, direction and terminal-count outputs, and feeds PWM/triangle-wave and scan-sequencing logic.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits, range 2..32.
- `HOLD_AT_ENDS`, default 1: in BOUNCE mode, 1 = dwell one cycle at each bound while direction flips (legacy behaviour); 0 = reverse immediately.

**Ports** (clock and reset first)
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; has priority over every other input.
- `en` in 1: count enable; when low, `cont` and `dir` hold.
- `mode` in 2: `0`=UP_WRAP, `1`=DOWN_WRAP, `2`=BOUNCE, `3`=reserved (behaves as hold).
- `lo` in WIDTH: lower bound, inclusive.
- `hi` in WIDTH: upper bound, inclusive.
- `load` in 1: parallel load strobe.
- `load_val` in WIDTH: value written on `load`.
- `cont` out WIDTH: registered count.
- `dir` out 1: registered direction, 0 = up, 1 = down.
- `tc` out 1: registered terminal-count pulse.
- `cfg_err` out 1: combinational, high when `lo > hi`.

## Operation

- **Reset:** `cont=0`, `dir=0`, `tc=0`.
- **Priority per edge:** `reset` > `load` > (`en` and valid config) > hold.
- **Load:**
  - `cont <= load_val` verbatim, with no clamping.
  - `dir` is forced to 0 in UP_WRAP and to 1 in DOWN_WRAP; it is unchanged in BOUNCE.
  - `tc <= 0`.
- **Invalid config** (`lo > hi`) or `mode=3`: `cont` and `dir` hold, `tc <= 0`; `load` still works.
- **Out-of-range recovery:** on an enabled cycle with `cont < lo` or `cont > hi`:
  - `cont <=` `hi` in DOWN_WRAP, otherwise `lo`.
  - `dir <=` 1 in DOWN_WRAP, otherwise 0.
  - `tc <= 0`.
  - This covers reset followed by `lo > 0`.
- **UP_WRAP:** `dir <= 0`. If `cont == hi`: `cont <= lo`, `tc <= 1`; else `cont <= cont + 1`.
- **DOWN_WRAP:** `dir <= 1`. If `cont == lo`: `cont <= hi`, `tc <= 1`; else `cont <= cont - 1`.
- **BOUNCE, state = `dir`** (UP/DOWN):
  - UP, `cont < hi`: `cont + 1`.
  - UP, `cont == hi`: `dir <= 1`, `tc <= 1`. `cont` holds if `HOLD_AT_ENDS=1`, else `cont <= hi - 1`.
  - DOWN, `cont > lo`: `cont - 1`.
  - DOWN, `cont == lo`: `dir <= 0`, `tc <= 1`. `cont` holds if `HOLD_AT_ENDS=1`, else `cont <= lo + 1`.
  - `lo == hi`: `cont` holds, `dir` toggles, and `tc` is 1 every enabled cycle, regardless of `HOLD_AT_ENDS`.
- **Mode change** takes effect on the next enabled edge. Entering BOUNCE keeps the current `dir`.
- **Arithmetic:** all increment/decrement is WIDTH bits. No wrap past all-ones or zero is possible because of the bound checks.
- **`tc`** is 0 on every cycle not listed above, including `en=0` cycles.

## Timing

- `cont`, `dir` and `tc` all update on the same edge. `tc` is high during exactly the cycle after the edge that performed the wrap or flip, coincident with the new `cont`.
- **Latency:** `load` is visible on `cont` 1 cycle after the strobe edge; `en` rising gives the first change after 1 edge.
- **Periods with `en` held high:**
  - UP_WRAP and DOWN_WRAP: `hi - lo + 1`.
  - BOUNCE, `HOLD_AT_ENDS=1`: `2*(hi - lo + 1)`. Default: 32.
  - BOUNCE, `HOLD_AT_ENDS=0`: `2*(hi - lo)`.
- **`lo`/`hi` changes mid-count:** sampled every edge; no pipeline.
- **Reset mid-operation:** overrides `load` and `en` on that edge.

## Structure

- **Package `updn_counter_pkg`:**
  - `typedef enum logic [1:0]` `mode_e` {UP_WRAP, DOWN_WRAP, BOUNCE, MODE_RSVD}.
  - Constants `DIR_UP=1'b0`, `DIR_DOWN=1'b1`.
- **No sub-module.** Use one `always_comb` computing `nxt_cont`, `nxt_dir` and `nxt_tc`, and one `always_ff` register stage.

## Test plan

- **Legacy match:** reset, then WIDTH=4, BOUNCE, `HOLD_AT_ENDS=1`, `lo=0`, `hi=15`, `en=1` → `cont` reads 0..15, 15, 14..0, 0, 1…; `tc` is high on the second 15 and the second 0; period is 32.
- **Immediate bounce:** `HOLD_AT_ENDS=0`, `lo=3`, `hi=6` → 3,4,5,6,5,4,3,4…; `tc` with `cont=5` after 6 and `cont=4` after 3; period 6.
- **Wrap modes with enable gaps:** UP_WRAP `lo=2`, `hi=5`, `en` toggled 1,1,0,1… → 0→2 recovery (`tc=0`), 3, hold, 4, 5, 2 with `tc=1`. DOWN_WRAP from 2 → 5 with `tc=1`, `dir=1`.
- **Load priority:** `load=1`, `load_val=9` and `en=1` on the same edge in UP_WRAP with `hi=7` → `cont=9`, `tc=0`; next enabled edge gives `cont=lo`.
- **Degenerate and invalid config:** `lo=hi=4` in BOUNCE → `cont` stays 4, `dir` alternates, `tc=1` every cycle. Then `lo=8`, `hi=2` → `cfg_err=1`, `cont` and `dir` frozen.
- **Reset mid-count:** `reset` asserted with `cont=11`, `dir=1`, `load=1` → next cycle `cont=0`, `dir=0`, `tc=0`.

Source files
------------

// File: rtl/updn_bounce_counter_pkg.sv
// Shared types for the bounded up/down/bounce counter.
// Mode encoding and direction constants.
package updn_counter_pkg;

    typedef enum logic [1:0] {
        UP_WRAP   = 2'd0,
        DOWN_WRAP = 2'd1,
        BOUNCE    = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updn_bounce_counter.sv
// Bounded counter: wrap-up, wrap-down or ping-pong between runtime lo/hi bounds.
// Latency: one edge for count, load and terminal-count; cfg_err is combinational.
// Backpressure: none; en gates advance, load and reset override it.
module updn_bounce_counter
    import updn_counter_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit HOLD_AT_ENDS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cont,
    output logic             dir,
    output logic             tc,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            cur_mode;
    logic [WIDTH-1:0] nxt_cont;
    logic             nxt_dir;
    logic             nxt_tc;
    logic             out_of_range;

    assign cur_mode     = mode_e'(mode);
    assign cfg_err      = (lo > hi);
    assign out_of_range = (cont < lo) || (cont > hi);

    always_comb begin
        nxt_cont = cont;
        nxt_dir  = dir;
        nxt_tc   = 1'b0;
        if (load) begin
            nxt_cont = load_val;
            if (cur_mode == UP_WRAP)
                nxt_dir = DIR_UP;
            else if (cur_mode == DOWN_WRAP)
                nxt_dir = DIR_DOWN;
        end else if (en && !cfg_err && cur_mode != MODE_RSVD) begin
            if (out_of_range) begin
                // Snap back to the bound the current mode would start from.
                nxt_cont = (cur_mode == DOWN_WRAP) ? hi : lo;
                nxt_dir  = (cur_mode == DOWN_WRAP) ? DIR_DOWN : DIR_UP;
            end else begin
                case (cur_mode)
                    UP_WRAP: begin
                        nxt_dir = DIR_UP;
                        if (cont == hi) begin
                            nxt_cont = lo;
                            nxt_tc   = 1'b1;
                        end else begin
                            nxt_cont = cont + ONE;
                        end
                    end
                    DOWN_WRAP: begin
                        nxt_dir = DIR_DOWN;
                        if (cont == lo) begin
                            nxt_cont = hi;
                            nxt_tc   = 1'b1;
                        end else begin
                            nxt_cont = cont - ONE;
                        end
                    end
                    BOUNCE: begin
                        if (lo == hi) begin
                            nxt_dir = ~dir;
                            nxt_tc  = 1'b1;
                        end else if (dir == DIR_UP) begin
                            if (cont < hi) begin
                                nxt_cont = cont + ONE;
                            end else begin
                                nxt_dir  = DIR_DOWN;
                                nxt_tc   = 1'b1;
                                nxt_cont = HOLD_AT_ENDS ? cont : hi - ONE;
                            end
                        end else begin
                            if (cont > lo) begin
                                nxt_cont = cont - ONE;
                            end else begin
                                nxt_dir  = DIR_UP;
                                nxt_tc   = 1'b1;
                                nxt_cont = HOLD_AT_ENDS ? cont : lo + ONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cont <= '0;
            dir  <= DIR_UP;
            tc   <= 1'b0;
        end else begin
            cont <= nxt_cont;
            dir  <= nxt_dir;
            tc   <= nxt_tc;
        end
    end

endmodule

// File: tb/tb_updn_bounce_counter.sv
// Directed bench: legacy ping-pong, immediate bounce, wrap modes, load, degenerate/invalid bounds, reset.
module tb_updn_bounce_counter;
    import updn_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] lo, hi, load_val;
    logic       load;
    logic [3:0] cont_a, cont_b;
    logic       dir_a, dir_b, tc_a, tc_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updn_bounce_counter #(.WIDTH(4), .HOLD_AT_ENDS(1'b1)) dut_hold (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
        .load(load), .load_val(load_val),
        .cont(cont_a), .dir(dir_a), .tc(tc_a), .cfg_err(err_a)
    );

    updn_bounce_counter #(.WIDTH(4), .HOLD_AT_ENDS(1'b0)) dut_imm (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
        .load(load), .load_val(load_val),
        .cont(cont_b), .dir(dir_b), .tc(tc_b), .cfg_err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] c, input logic d, input logic t);
        chk({tag, ".cont"}, {28'd0, cont_a}, {28'd0, c});
        chk({tag, ".dir"},  {31'd0, dir_a},  {31'd0, d});
        chk({tag, ".tc"},   {31'd0, tc_a},   {31'd0, t});
    endtask

    initial begin
        int imm_c [11];
        int imm_t [11];
        int imm_d [11];
        imm_c = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5};
        imm_t = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        imm_d = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

        reset = 1'b1; en = 1'b0; mode = BOUNCE; lo = 4'd0; hi = 4'd15;
        load = 1'b0; load_val = 4'd0;
        tick(); tick();
        chk_a("reset", 4'd0, 1'b0, 1'b0);
        chk("reset.cfg_err", {31'd0, err_a}, 32'd0);
        chk("reset_imm.cont", {28'd0, cont_b}, 32'd0);

        // Legacy ping-pong 0..15,15,14..0,0,1.. with tc on the repeated ends.
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            int i;
            logic [3:0] ec;
            logic ed, et;
            tick();
            i = k % 32;
            if (i == 0)       begin ec = 4'd0;        ed = 1'b0; et = 1'b1; end
            else if (i <= 15) begin ec = 4'(i);       ed = 1'b0; et = 1'b0; end
            else if (i == 16) begin ec = 4'd15;       ed = 1'b1; et = 1'b1; end
            else              begin ec = 4'(31 - i);  ed = 1'b1; et = 1'b0; end
            chk_a($sformatf("legacy[%0d]", k), ec, ed, et);
        end

        // Immediate bounce on the HOLD_AT_ENDS=0 instance.
        reset = 1'b1; tick();
        reset = 1'b0; lo = 4'd3; hi = 4'd6;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk($sformatf("imm[%0d].cont", k), {28'd0, cont_b}, imm_c[k]);
            chk($sformatf("imm[%0d].tc", k),   {31'd0, tc_b},   imm_t[k]);
            chk($sformatf("imm[%0d].dir", k),  {31'd0, dir_b},  imm_d[k]);
        end

        // Wrap modes with an enable gap.
        reset = 1'b1; tick();
        reset = 1'b0; mode = UP_WRAP; lo = 4'd2; hi = 4'd5; en = 1'b1;
        tick(); chk_a("up.recover", 4'd2, 1'b0, 1'b0);
        tick(); chk_a("up.3", 4'd3, 1'b0, 1'b0);
        en = 1'b0;
        tick(); chk_a("up.hold", 4'd3, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk_a("up.4", 4'd4, 1'b0, 1'b0);
        tick(); chk_a("up.5", 4'd5, 1'b0, 1'b0);
        tick(); chk_a("up.wrap", 4'd2, 1'b0, 1'b1);
        mode = DOWN_WRAP;
        tick(); chk_a("dn.wrap", 4'd5, 1'b1, 1'b1);
        tick(); chk_a("dn.4", 4'd4, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk_a("dn.en0", 4'd4, 1'b1, 1'b0);

        // Load beats enable and is not clamped.
        mode = UP_WRAP; hi = 4'd7; en = 1'b1; load = 1'b1; load_val = 4'd9;
        tick(); chk_a("load", 4'd9, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_a("load.recover", 4'd2, 1'b0, 1'b0);

        // Degenerate single-value bounce.
        mode = BOUNCE; lo = 4'd4; hi = 4'd4;
        tick(); chk_a("degen.recover", 4'd4, 1'b0, 1'b0);
        tick(); chk_a("degen.1", 4'd4, 1'b1, 1'b1);
        tick(); chk_a("degen.2", 4'd4, 1'b0, 1'b1);
        tick(); chk_a("degen.3", 4'd4, 1'b1, 1'b1);

        // Inverted bounds freeze the count but still accept a load.
        lo = 4'd8; hi = 4'd2;
        #1 chk("invalid.cfg_err", {31'd0, err_a}, 32'd1);
        tick(); chk_a("invalid.1", 4'd4, 1'b1, 1'b0);
        tick(); chk_a("invalid.2", 4'd4, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd13;
        tick(); chk_a("invalid.load", 4'd13, 1'b1, 1'b0);
        load = 1'b0;
        tick(); chk_a("invalid.3", 4'd13, 1'b1, 1'b0);

        // Reset overrides load and enable mid-count.
        lo = 4'd0; hi = 4'd15;
        #1 chk("valid.cfg_err", {31'd0, err_a}, 32'd0);
        mode = DOWN_WRAP; load = 1'b1; load_val = 4'd12;
        tick(); chk_a("dnload", 4'd12, 1'b1, 1'b0);
        load = 1'b0;
        tick(); chk_a("pre_reset", 4'd11, 1'b1, 1'b0);
        reset = 1'b1; load = 1'b1; load_val = 4'd5;
        tick(); chk_a("mid_reset", 4'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
